// File: rtl/aes192_ecb_encrypt.sv
// Iterative AES-192 ECB encryption core with a parameter-fixed key.
// One round per enabled clock; round keys are expanded at elaboration.
module aes192_ecb_encrypt #(
   parameter logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         enable_i,
   input  logic         process_start_i,
   output logic         busy_o,
   input  logic [127:0] bytes_i,
   output logic [127:0] bytes_o,
   output logic         bytes_valid_o
);

   localparam logic [3:0] LAST_ROUND = 4'd12;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry x sits at the high end for x=0, so index from the top.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{8'hff - x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes are row 0 in the LSB, matching the bytes_i ordering.
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
   endfunction

   // Thirteen 128-bit round keys, round r at [128r +: 128], byte n at [8n +: 8].
   function automatic logic [1663:0] expand_key(input logic [191:0] key);
      logic [51:0][31:0] w;
      logic [31:0]       t;
      logic [7:0]        rc;
      logic [1663:0]     rk;
      for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 6; i < 52; i++) begin
         t = w[i-1];
         if (i % 6 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            t[31:24] = t[31:24] ^ rc;
            rc = xtime(rc);
         end
         w[i] = w[i-6] ^ t;
      end
      for (int r = 0; r < 13; r++)
         for (int n = 0; n < 16; n++)
            rk[128*r + 8*n +: 8] = w[4*r + n/4][31 - 8*(n%4) -: 8];
      return rk;
   endfunction

   localparam logic [1663:0] ROUND_KEYS = expand_key(KEY);

   logic [127:0] state_r;
   logic [127:0] bytes_r;
   logic [3:0]   round_r;
   logic         busy_r;
   logic         valid_r;
   logic [127:0] rk_s;
   logic [127:0] sub_s;
   logic [127:0] shift_s;
   logic [127:0] mix_s;
   logic [127:0] next_s;

   // One AES round on the current state; idle round_r=0 selects the whitening key.
   always_comb begin
      rk_s    = ROUND_KEYS[{round_r, 7'h00} +: 128];
      sub_s   = 128'h0;
      shift_s = 128'h0;
      mix_s   = 128'h0;
      for (int n = 0; n < 16; n++) sub_s[8*n +: 8] = sbox(state_r[8*n +: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shift_s[8*(4*c + r) +: 8] = sub_s[8*(4*((c + r) % 4) + r) +: 8];
      for (int c = 0; c < 4; c++) mix_s[32*c +: 32] = mix_col(shift_s[32*c +: 32]);
      if (round_r == LAST_ROUND) begin
         next_s = shift_s ^ rk_s;
      end else begin
         next_s = mix_s ^ rk_s;
      end
   end

   // Control and datapath registers; valid drops every edge regardless of enable.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_r <= 128'h0;
         bytes_r <= 128'h0;
         round_r <= 4'd0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         if (enable_i) begin
            if (busy_r) begin
               if (round_r == LAST_ROUND) begin
                  bytes_r <= next_s;
                  valid_r <= 1'b1;
                  busy_r  <= 1'b0;
                  round_r <= 4'd0;
               end else begin
                  state_r <= next_s;
                  round_r <= round_r + 4'd1;
               end
            end else if (process_start_i) begin
               state_r <= bytes_i ^ rk_s;
               round_r <= 4'd1;
               busy_r  <= 1'b1;
            end
         end
      end
   end

   assign busy_o        = busy_r;
   assign bytes_o       = bytes_r;
   assign bytes_valid_o = valid_r;

endmodule

// File: tb/tb_aes192_ecb_encrypt.sv
// Scoreboard bench for aes192_ecb_encrypt: a cycle-level timing reference plus
// an independent byte-array AES-192 model (S-box derived from GF inverses).
module tb_aes192_ecb_encrypt;

   localparam logic [191:0] DEF_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [191:0] K2      = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [127:0] PT1     = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] EXP1    = 128'h91710deca070af6ee0df4c86a47ca9dd;
   localparam logic [127:0] PT2     = 128'h2a179373117e3de9969f402ee2bec16b;
   localparam logic [127:0] EXP2    = 128'hcca51f5714a212f75ff2456e1d4f33bd;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         start;
   logic [127:0] din;
   logic         busy_o, valid_o, busy_k2, valid_k2;
   logic [127:0] dout, dout_k2;

   logic [127:0] cur_exp;
   logic [127:0] exp_q[$];
   bit           ref_busy, ref_valid;
   bit [3:0]     ref_cnt;
   bit [127:0]   ref_bytes;
   bit           chk_on;
   int           n_cmp, n_bad;
   logic [7:0]   sb [256];

   always #5 clk = ~clk;

   aes192_ecb_encrypt #(.KEY(DEF_KEY)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .process_start_i(start),
      .busy_o(busy_o), .bytes_i(din), .bytes_o(dout), .bytes_valid_o(valid_o));

   aes192_ecb_encrypt #(.KEY(K2)) dut_k2 (
      .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .process_start_i(start),
      .busy_o(busy_k2), .bytes_i(din), .bytes_o(dout_k2), .bytes_valid_o(valid_k2));

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [191:0] key, input logic [127:0] pt);
      logic [7:0] k [208];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] tmp [4];
      logic [7:0] x0, rc;
      logic [127:0] out;
      for (int i = 0; i < 24; i++) k[i] = key[191 - 8*i -: 8];
      rc = 8'h01;
      for (int i = 24; i < 208; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = k[i - 4 + j];
         if ((i / 4) % 6 == 0) begin
            x0 = tmp[0];
            tmp[0] = sb[tmp[1]] ^ rc;
            tmp[1] = sb[tmp[2]];
            tmp[2] = sb[tmp[3]];
            tmp[3] = sb[x0];
            rc = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) k[i + j] = k[i - 24 + j] ^ tmp[j];
      end
      for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ k[n];
      for (int r = 1; r <= 12; r++) begin
         for (int n = 0; n < 16; n++) t[n] = sb[s[4*((n/4 + n%4) % 4) + n%4]];
         for (int c = 0; c < 4; c++) begin
            if (r < 12) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[16*r + n];
      end
      for (int n = 0; n < 16; n++) out[8*n +: 8] = s[n];
      return out;
   endfunction

   // Cycle-level reference of busy/valid/bytes_o; expected blocks queued on acceptance.
   always @(posedge clk) begin
      if (!rst_n) begin
         ref_busy  <= 1'b0;
         ref_cnt   <= 4'd0;
         ref_valid <= 1'b0;
         ref_bytes <= 128'h0;
         exp_q.delete();
      end else begin
         ref_valid <= 1'b0;
         if (enable) begin
            if (ref_busy) begin
               if (ref_cnt == 4'd12) begin
                  ref_valid <= 1'b1;
                  ref_busy  <= 1'b0;
                  ref_cnt   <= 4'd0;
                  if (exp_q.size() > 0) ref_bytes <= exp_q.pop_front();
               end else begin
                  ref_cnt <= ref_cnt + 4'd1;
               end
            end else if (start) begin
               ref_busy <= 1'b1;
               ref_cnt  <= 4'd1;
               exp_q.push_back(cur_exp);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_on) begin
         check("busy", 128'(busy_o), 128'(ref_busy));
         check("valid", 128'(valid_o), 128'(ref_valid));
         check("bytes_o", dout, ref_bytes);
      end
   endtask

   task automatic launch(input logic [127:0] pt, input logic [127:0] ex);
      din = pt; cur_exp = ex; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int lat);
      bit done;
      done = 1'b0; lat = 0;
      while (!done && lat < 60) begin
         tick();
         lat++;
         done = valid_o;
      end
      if (!done) check({tag, "_timeout"}, 128'd0, 128'd1);
   endtask

   initial begin
      logic [7:0]   inv;
      logic [127:0] blk [8];
      logic [127:0] ex;
      int           lat, pulses, busyc;
      bit           done;
      n_cmp = 0; n_bad = 0; chk_on = 1'b0;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      rst_n = 1'b0; enable = 1'b1; start = 1'b0; din = 128'h0; cur_exp = 128'h0;
      tick(); tick();
      chk_on = 1'b1;
      check("rst_busy", 128'(busy_o), 128'd0);
      check("rst_bytes", dout, 128'h0);
      rst_n = 1'b1;
      tick();

      // 1: FIPS-197 AES-192 vector
      launch(PT1, EXP1);
      wait_valid("t1", lat);
      check("t1_lat", 128'(lat), 128'd12);
      check("t1_ct", dout, EXP1);
      tick();

      // 2: alternate key on the second instance
      launch(PT2, aes_ref(DEF_KEY, PT2));
      wait_valid("t2", lat);
      check("t2_ct_k2", dout_k2, EXP2);
      check("t2_ct_def", dout, aes_ref(DEF_KEY, PT2));
      tick();

      // 3: start held for 8 cycles, then restart in the valid cycle
      for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
      pulses = 0; busyc = 0; done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         din = blk[i]; cur_exp = aes_ref(DEF_KEY, blk[i]); start = 1'b1;
         tick();
         if (busy_o) busyc++;
         if (valid_o) pulses++;
      end
      start = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         if (busy_o) busyc++;
         if (valid_o) begin pulses++; done = 1'b1; end
      end
      check("t3_busy_cycles", 128'(busyc), 128'd12);
      check("t3_pulses", 128'(pulses), 128'd1);
      check("t3_ct", dout, aes_ref(DEF_KEY, blk[0]));
      launch(blk[7], aes_ref(DEF_KEY, blk[7]));
      wait_valid("t3b", lat);
      check("t3b_lat", 128'(lat), 128'd12);
      tick();

      // 4: enable dropped for 5 cycles mid-block, and during the valid cycle
      ex = aes_ref(DEF_KEY, blk[3]);
      launch(blk[3], ex);
      lat = 0; done = 1'b0;
      while (!done && lat < 60) begin
         tick();
         lat++;
         if (lat == 4) enable = 1'b0;
         if (lat == 9) enable = 1'b1;
         done = valid_o;
      end
      check("t4_lat", 128'(lat), 128'd17);
      check("t4_ct", dout, ex);
      enable = 1'b0;
      tick();
      check("t4_valid_clear", 128'(valid_o), 128'd0);
      enable = 1'b1;
      tick();

      // 5: reset at round 6
      launch(blk[4], aes_ref(DEF_KEY, blk[4]));
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check("t5_busy", 128'(busy_o), 128'd0);
      check("t5_valid", 128'(valid_o), 128'd0);
      check("t5_bytes", dout, 128'h0);
      rst_n = 1'b1;
      pulses = 0;
      repeat (20) begin
         tick();
         if (valid_o) pulses++;
      end
      check("t5_no_pulse", 128'(pulses), 128'd0);
      ex = aes_ref(DEF_KEY, blk[5]);
      launch(blk[5], ex);
      wait_valid("t5b", lat);
      check("t5b_lat", 128'(lat), 128'd12);
      check("t5b_ct", dout, ex);
      tick();

      // 6: back-to-back, zero block started in the valid cycle
      launch(PT1, EXP1);
      wait_valid("t6a", lat);
      check("t6a_ct", dout, EXP1);
      ex = aes_ref(DEF_KEY, 128'h0);
      launch(128'h0, ex);
      wait_valid("t6b", lat);
      check("t6b_gap", 128'(lat), 128'd12);
      check("t6b_ct", dout, ex);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
